tnn_eval_sequencer: RTL
=======================

# tnn_eval_sequencer

Sequencer that streams quantised feature vectors through one shared combinational approximate TNN classifier core and returns per-sample class bits plus a per-batch positive count. It sits between the sample source (dataset loader or host FIFO) and the core. The core has five 3-bit features and a 1-bit output. The sequencer holds the core's inputs stable for a programmable settle window, captures the output, and applies valid/ready backpressure on both sides.

## Interface
Parameters:
- `N_FEAT`, 5 — number of features per sample.
- `FEAT_W`, 3 — bits per feature.
- `SETTLE`, 1 — extra cycles (≥0) that core inputs are held before `core_out` is captured. Covers the multicycle path through the core.
- `CNT_W`, 8 — width of sample index and positive counter.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — reset, synchronous, active-high.
- `s_valid` in 1 — sample offered.
- `s_ready` out 1 — sequencer can accept a sample.
- `s_feat` in N_FEAT*FEAT_W — packed features; feature i occupies bits [FEAT_W*i+FEAT_W-1 : FEAT_W*i]; i=0 maps to core input a, i=4 to core input e.
- `s_last` in 1 — this sample closes the batch.
- `core_in` out N_FEAT*FEAT_W — registered drive to the classifier core.
- `core_out` in 1 — classifier result, combinational from `core_in`.
- `m_valid` out 1 — result available.
- `m_ready` in 1 — consumer accepts result.
- `m_class` out 1 — captured class bit.
- `m_idx` out CNT_W — index of this sample within its batch, starting at 0.
- `m_last` out 1 — echo of `s_last`.
- `m_pos_cnt` out CNT_W — positives in the batch up to and including this sample.

## Operation
- FSM states: IDLE, HOLD, EMIT.
- IDLE:
  - `s_ready`=1.
  - On `s_valid`&`s_ready`: register `s_feat` into `core_in` and `s_last` into the last flag; load the hold counter with SETTLE; go to HOLD.
- HOLD:
  - `s_ready`=0 and `core_in` is stable.
  - While the hold counter is nonzero, decrement it.
  - When it is zero: capture `core_out` into `m_class`; set `m_pos_cnt` to the running count plus `core_out`; go to EMIT.
  - HOLD therefore lasts SETTLE+1 cycles.
- EMIT:
  - `m_valid`=1; `m_class`, `m_idx`, `m_last` and `m_pos_cnt` stay stable until the handshake.
  - On `m_valid`&`m_ready`:
    - If last: clear the running count and the index.
    - Otherwise: running count = `m_pos_cnt`; index++.
    - Go to IDLE.
- No new sample is accepted until the result handshake completes. There is one sample in flight.
- `core_in` keeps its last value in IDLE and EMIT. It changes only on acceptance.
- Arithmetic:
  - Index and positive count saturate at 2^CNT_W−1 and never wrap.
  - A batch longer than 2^CNT_W reports the saturated index for all remaining samples.
- Reset values:
  - State=IDLE, `s_ready`=1, `m_valid`=0.
  - `core_in`=0, `m_class`=0, `m_idx`=0, `m_last`=0, `m_pos_cnt`=0.
  - Running count=0, hold counter=0.
- Reset mid-operation: the in-flight sample and partial batch are discarded with no result emitted. The next accepted sample has index 0.

## Timing
- Acceptance edge at the end of cycle T; `core_in` is new from cycle T+1.
- Capture edge at the end of cycle T+SETTLE+1.
- `m_valid` is first high in cycle T+SETTLE+2.
- If `m_ready` is held high, `s_ready` returns in cycle T+SETTLE+3.
- Peak throughput is one sample per SETTLE+3 cycles.
- `m_ready` may be asserted before `m_valid`; it has no effect outside EMIT.
- `s_valid` may drop without acceptance; the sequencer has no dependence on `s_valid` stability.
- With `rst` and a handshake on the same edge, reset wins.
- The core path from `core_in` to `core_out` is a declared multicycle path of SETTLE+1 cycles.

## Structure
- Shared package `tnn_pkg` holds:
  - N_FEAT and FEAT_W defaults.
  - Packed feature-vector typedef.
  - FSM state enum.
  - Packing helper function for feature index to bit slice.
- The classifier core is not instantiated inside this block. The top level wires `core_in`/`core_out` so approximate variants can be swapped.
- One sub-module is natural: `tnn_sat_counter` (parameterised width, clear, increment-by-bit, saturating), used for both index and positive count.

## Test plan
- Bench core stub: `core_out` = XOR of all `core_in` bits.
- Single sample, SETTLE=1, features {1,0,0,0,0}, `s_last`=1, `m_ready`=1 -> `m_valid` in cycle T+3; `m_class`=1, `m_idx`=0, `m_last`=1, `m_pos_cnt`=1; `s_ready` back in T+4.
- Batch of 4 samples with parities 1,0,1,1, last on sample 4 -> `m_idx` 0,1,2,3; `m_pos_cnt` 1,1,2,3. The next batch restarts at idx 0, count 0|1.
- Backpressure: hold `m_ready`=0 for 5 cycles in EMIT -> outputs stable, `s_ready`=0 throughout; completion occurs on the first cycle `m_ready`=1.
- SETTLE=0 and SETTLE=3 builds -> `m_valid` at T+2 and T+5 respectively; `core_in` unchanged across HOLD.
- CNT_W=2, 6 positive samples in one batch -> `m_idx` 0,1,2,3,3,3; `m_pos_cnt` 1,2,3,3,3,3.
- Assert `rst` for 1 cycle during HOLD -> no `m_valid`; all outputs at reset values; next sample reports idx 0, count = its class bit.

Source files
------------

// File: rtl/tnn_pkg.sv
// tnn_pkg: shared defaults, types and helpers for the TNN evaluation sequencer.
// Contents: default feature geometry, packed feature-vector type, sequencer
// FSM state enum, and a helper that maps a feature index to its bit offset.
package tnn_pkg;
   localparam int DEF_N_FEAT = 5;
   localparam int DEF_FEAT_W = 3;
   typedef logic [DEF_N_FEAT*DEF_FEAT_W-1:0] feat_vec_t;
   typedef enum logic [1:0] {IDLE, HOLD, EMIT} seq_state_t;
   function automatic int feat_lsb(input int i, input int w);
      return i * w;
   endfunction
endpackage

// File: rtl/tnn_eval_sequencer_if.sv
// tnn_eval_sequencer_if: sample-in and result-out handshake bundle.
// Sample channel: s_valid, s_ready, s_feat, s_last.
// Result channel: m_valid, m_ready, m_class, m_idx, m_last, m_pos_cnt.
// Modport slave is the sequencer side; master is the source/consumer side.
interface tnn_eval_sequencer_if import tnn_pkg::*; #(
   parameter int N_FEAT = DEF_N_FEAT,
   parameter int FEAT_W = DEF_FEAT_W,
   parameter int CNT_W  = 8
);
   logic                     s_valid, s_ready, s_last;
   logic [N_FEAT*FEAT_W-1:0] s_feat;
   logic                     m_valid, m_ready, m_class, m_last;
   logic [CNT_W-1:0]         m_idx, m_pos_cnt;
   modport slave (
      input  s_valid, s_feat, s_last, m_ready,
      output s_ready, m_valid, m_class, m_idx, m_last, m_pos_cnt
   );
   modport master (
      output s_valid, s_feat, s_last, m_ready,
      input  s_ready, m_valid, m_class, m_idx, m_last, m_pos_cnt
   );
endinterface

// File: rtl/tnn_sat_counter.sv
// tnn_sat_counter: saturating up-counter that adds a single bit when enabled.
// Ports: clk, rst (sync, active-high), clr (sync clear, beats en),
//        en (apply increment), inc (bit to add), q (count, sticks at all-ones).
module tnn_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         inc,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst || clr) q <= '0;
      else if (en && !(&q)) q <= q + W'(inc);
   end
endmodule

// File: rtl/tnn_eval_sequencer.sv
// tnn_eval_sequencer: streams feature vectors through an external combinational
// classifier core, one sample in flight, returning class bit, batch index and
// running positive count per sample.
// Ports: clk, rst (sync, active-high); bus (sample/result handshakes);
//        core_in (registered drive to the core), core_out (core result).
module tnn_eval_sequencer import tnn_pkg::*; #(
   parameter int N_FEAT = DEF_N_FEAT,
   parameter int FEAT_W = DEF_FEAT_W,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   tnn_eval_sequencer_if.slave      bus,
   output logic [N_FEAT*FEAT_W-1:0] core_in,
   input  logic                     core_out
);
   localparam int HW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   seq_state_t    state, state_nxt;
   logic [HW-1:0] hold;
   logic          acc, cap, hs;
   assign acc = (state == IDLE) && bus.s_valid;
   assign cap = (state == HOLD) && (hold == '0);
   assign hs  = (state == EMIT) && bus.m_ready;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt   = state;
      if (acc) state_nxt = HOLD;
      if (cap) state_nxt = EMIT;
      if (hs) state_nxt = IDLE;
      bus.s_ready = state == IDLE;
      bus.m_valid = state == EMIT;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         core_in     <= '0;
         hold        <= '0;
         bus.m_last  <= 1'b0;
         bus.m_class <= 1'b0;
      end else begin
         if (acc) begin
            core_in    <= bus.s_feat;
            bus.m_last <= bus.s_last;
            hold       <= HW'(SETTLE);
         end else if (state == HOLD && hold != '0) begin
            hold <= hold - HW'(1);
         end
         if (cap) bus.m_class <= core_out;
      end
   end
   // The index advances only when a non-last result is taken, so it already
   // reads as the current sample's position while EMIT holds.
   tnn_sat_counter #(.W(CNT_W)) u_idx (
      .clk (clk),
      .rst (rst),
      .clr (hs && bus.m_last),
      .en  (hs),
      .inc (1'b1),
      .q   (bus.m_idx)
   );
   // The positive count doubles as the running count: it absorbs core_out at
   // capture and is only zeroed when the batch's last result is taken.
   tnn_sat_counter #(.W(CNT_W)) u_pos (
      .clk (clk),
      .rst (rst),
      .clr (hs && bus.m_last),
      .en  (cap),
      .inc (core_out),
      .q   (bus.m_pos_cnt)
   );
endmodule
